// File: rtl/rs232_pkg.sv
// rs232_pkg: shared definitions for the RS-232 transmit path (and, later, the
// receive path).
//   - rs232_state_e : frame state machine encoding
//   - PAR_*         : parity mode selectors
//   - CLKS_PER_BIT_9600_100M : bit period for 9600 baud from a 100 MHz clock
//   - parity_of()   : parity bit for a byte under a given mode
package rs232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rs232_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int CLKS_PER_BIT_9600_100M = 10416;

    // Even parity makes the total count of ones (data + parity) even.
    function automatic logic parity_of(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// rs232_baud_gen: bit-period timer shared by the RS-232 transmit and receive
// paths. A down-counter reloads to CLKS_PER_BIT-1 on restart and on reaching
// zero, so every bit period is exactly CLKS_PER_BIT cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : load the counter for a fresh bit period (first bit of a frame)
//   enable     : count while high; counter holds while low
//   bit_end    : high on the last cycle of each bit period
module rs232_baud_gen #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = RELOAD;
        end else if (enable) begin
            // Reload on zero rather than wrapping, so no extra cycle appears.
            count_d = (count_q == '0) ? RELOAD : (count_q - CW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_end = enable & ~restart & (count_q == '0);

endmodule

// File: rtl/rs232_transmit.sv
// rs232_transmit: 8-bit RS-232 transmitter. Takes one byte per valid/ready
// handshake and sends start bit, 8 data bits LSB-first, optional parity and
// 1 or 2 stop bits. The line idles high.
//   clk, rst_n : clock, asynchronous active-low reset
//   tx_data    : byte to send, sampled on the accept cycle only
//   tx_valid   : tx_data is valid
//   tx_ready   : block can accept a byte (IDLE only)
//   serial_out : registered TX line
//   busy       : a frame is in progress
//   done       : one-cycle pulse on the edge the frame completes
//   state_dbg  : current FSM state, for observation
// Handshake: a byte is accepted on a rising edge where tx_valid and tx_ready
// are both high; tx_ready then stays low until the frame completes, and the
// source may change or drop tx_data/tx_valid freely while tx_ready is low.
module rs232_transmit
    import rs232_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("rs232_transmit: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("rs232_transmit: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("rs232_transmit: STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    rs232_state_e state_q, state_d;
    logic [7:0]   data_q, data_d;
    logic [2:0]   bit_idx_q, bit_idx_d;
    logic         serial_out_q, serial_out_d;
    logic         done_q, done_d;

    logic accept;
    logic bit_end;

    assign accept = tx_valid & (state_q == ST_IDLE);

    rs232_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (accept),
        .enable  (state_q != ST_IDLE),
        .bit_end (bit_end)
    );

    // State register (also holds the datapath flops).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            bit_idx_q    <= '0;
            serial_out_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            bit_idx_q    <= bit_idx_d;
            serial_out_q <= serial_out_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic. bit_idx counts data bits in DATA and stop bits in STOP.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    data_d    = tx_data;
                    bit_idx_d = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_STOP) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = '0;
            end
        endcase
    end

    // Output logic. The line value is decoded from the next state so that
    // serial_out is registered yet changes on the same edge as the state.
    always_comb begin
        serial_out_d = 1'b1;
        case (state_d)
            ST_START:  serial_out_d = 1'b0;
            ST_DATA:   serial_out_d = data_d[bit_idx_d];
            ST_PARITY: serial_out_d = parity_of(data_q, PARITY);
            default:   serial_out_d = 1'b1;
        endcase
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
    end

    assign tx_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign serial_out = serial_out_q;
    assign done       = done_q;
    assign state_dbg  = state_q;

endmodule
